mips_mem_model: RTL and testbench
=================================

// Module: mips_mem_model
// PURPOSE
//  Parametrised, cycle-accurate memory model serving a MIPS core: one read-only
//  instruction port (IM) and one read/write data port (DM) with byte enables.
//  Each port is a request/response pipeline with configurable read latency.
//  A load port preloads instruction memory without a file read.
//  Replaces the inline instruction and data arrays in the core test benches.
// PARAMETERS
//  AW       10   word-address bits; each array holds 2**AW words of 32 bits
//  IM_LAT   1    IM read latency in cycles, legal range 1..4
//  DM_LAT   1    DM read latency in cycles, legal range 1..4
// PORTS
//  CLK         in   1   single clock; all state updates on the rising edge
//  Z_R         in   1   reset, asynchronous, active-low
//  LD_WE       in   1   instruction-array load strobe
//  LD_ADDR     in   AW  instruction-array word address for the load
//  LD_DATA     in   32  instruction word to load
//  IM_REQ      in   1   instruction fetch request
//  IM_ADDR     in   32  fetch byte address
//  IM_DATA     out  32  fetched word
//  IM_VALID    out  1   IM_DATA valid; one-cycle pulse per accepted request
//  IM_ERR      out  1   fetch fault; qualified by IM_VALID
//  DM_REQ      in   1   data request
//  DM_WE       in   1   1 = write, 0 = read; sampled with DM_REQ
//  DM_BE       in   4   byte enables; bit i selects bits [8i+7:8i]
//  DM_ADDR     in   32  data byte address
//  DM_WR_DATA  in   32  write data
//  DM_RD_DATA  out  32  read data
//  DM_VALID    out  1   response pulse for every accepted DM request (read or write)
//  DM_ERR      out  1   data fault; qualified by DM_VALID
// BEHAVIOUR
//  Reset (Z_R=0):
//   - clears all pipeline valid bits.
//   - IM_DATA, DM_RD_DATA, IM_VALID, DM_VALID, IM_ERR and DM_ERR go to 0 immediately.
//   - array contents are retained.
//   - in-flight requests are dropped; no response follows release.
//  Accept and index:
//   - Both ports are fully pipelined. A request is accepted on every edge where REQ=1; there is no back-pressure.
//   - Word index = ADDR[AW+1:2].
//  Faults (misaligned: ADDR[1:0]!=0; out of range: ADDR[31:AW+2]!=0):
//   - response carries ERR=1 and data 0.
//   - a faulting DM write does not modify the array.
//  Read response:
//   - Read data is sampled from the array at the accept edge.
//   - It is presented LAT edges after acceptance: after accept edge t, VALID=1 and DATA are held from edge t+LAT-1 until edge t+LAT.
//   - The response is a shift pipeline LAT deep, so back-to-back requests yield back-to-back responses in order.
//  DM write:
//   - commits at the accept edge. Only bytes with DM_BE[i]=1 update.
//   - DM_BE=0000 is a legal no-op write that still returns VALID.
//   - The response for a write has DM_RD_DATA=0, timed like a read.
//   - A read accepted on a later edge sees the new data.
//  Load port:
//   - LD_WE writes LD_DATA at LD_ADDR on the edge.
//   - If an IM fetch of the same word is accepted on the same edge, the fetch returns the OLD word (read-before-write).
//   - The load port is ignored while Z_R=0.
//  Ports are independent: the IM and DM arrays are separate, and simultaneous activity on both ports never interacts.
//  VALID is 0 in every cycle with no matured response. DATA holds its last value when VALID=0, except after reset, where it is 0.
//  Illegal IM_LAT/DM_LAT values: stop elaboration with $error.
// TESTING
//  1 Reset then preload:
//    - Z_R=0 for 2 cycles; all outputs 0.
//    - Load words 0..3 = 0x20080005,0x20090007,0x01095020,0xAC0A0010.
//    - Fetch at 0x0,0x4,0x8,0xC back-to-back with IM_LAT=1 -> four consecutive IM_VALID pulses with those words, IM_ERR=0.
//  2 Byte-enabled write/read:
//    - Write 0xDEADBEEF, BE=1111, to 0x40; then write 0x000000AA, BE=0001.
//    - Read 0x40 -> 0xDEADBEAA.
//    - Write with BE=0000 -> DM_VALID=1 and the word is unchanged.
//  3 Latency:
//    - DM_LAT=3: read accepted at edge t -> DM_VALID high only in the cycle after edge t+2.
//    - Three back-to-back reads -> three consecutive pulses in order.
//  4 Faults:
//    - Read at 0x42 -> DM_ERR=1, data 0.
//    - Write to 0x00001000 (AW=10) -> DM_ERR=1; a following read of 0x0 is unchanged.
//  5 Reset mid-flight:
//    - DM_LAT=4: issue a read, assert Z_R=0 two cycles later -> outputs 0 at once.
//    - No DM_VALID after release.
//    - A read of the same address afterwards returns the pre-reset content.
//  6 Same-edge load/fetch of word 2:
//    - IM returns the old word.
//    - The next fetch of word 2 returns the new word.

Source files
------------

// File: rtl/mips_mem_if.sv
// Bus bundle for mips_mem_model: instruction load port, instruction fetch port
// and data port. Signal suffixes are from the memory model's point of view.
interface mips_mem_if #(parameter int AW = 10) ();
    logic          ld_we_i;
    logic [AW-1:0] ld_addr_i;
    logic [31:0]   ld_data_i;

    logic          im_req_i;
    logic [31:0]   im_addr_i;
    logic [31:0]   im_data_o;
    logic          im_valid_o;
    logic          im_err_o;

    logic          dm_req_i;
    logic          dm_we_i;
    logic [3:0]    dm_be_i;
    logic [31:0]   dm_addr_i;
    logic [31:0]   dm_wr_data_i;
    logic [31:0]   dm_rd_data_o;
    logic          dm_valid_o;
    logic          dm_err_o;

    modport master (
        output ld_we_i, ld_addr_i, ld_data_i,
        output im_req_i, im_addr_i,
        input  im_data_o, im_valid_o, im_err_o,
        output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wr_data_i,
        input  dm_rd_data_o, dm_valid_o, dm_err_o
    );

    modport slave (
        input  ld_we_i, ld_addr_i, ld_data_i,
        input  im_req_i, im_addr_i,
        output im_data_o, im_valid_o, im_err_o,
        input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wr_data_i,
        output dm_rd_data_o, dm_valid_o, dm_err_o
    );
endinterface

// File: rtl/mips_mem_model.sv
// Cycle-accurate instruction/data memory for a MIPS core: read-only IM port with a
// preload strobe, byte-enabled DM port, each with a LAT-deep response pipeline.
module mips_mem_model #(
    parameter int AW     = 10,
    parameter int IM_LAT = 1,
    parameter int DM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mips_mem_if.slave  bus
);
    localparam int WORDS = 2 ** AW;

    if (IM_LAT < 1 || IM_LAT > 4) begin : g_bad_im_lat
        $error("mips_mem_model: IM_LAT must be 1..4");
    end
    if (DM_LAT < 1 || DM_LAT > 4) begin : g_bad_dm_lat
        $error("mips_mem_model: DM_LAT must be 1..4");
    end

    logic [31:0]       im_mem_q [WORDS];
    logic [31:0]       dm_mem_q [WORDS];

    logic [AW-1:0]     im_idx;
    logic [AW-1:0]     dm_idx;
    logic              im_fault;
    logic              dm_fault;
    logic [31:0]       im_rd_d;
    logic [31:0]       dm_rd_d;
    logic [31:0]       dm_merge_d;

    logic [IM_LAT-1:0] im_v_q;
    logic [IM_LAT-1:0] im_e_q;
    logic [31:0]       im_dat_q [IM_LAT];
    logic [DM_LAT-1:0] dm_v_q;
    logic [DM_LAT-1:0] dm_e_q;
    logic [31:0]       dm_dat_q [DM_LAT];

    assign im_idx   = bus.im_addr_i[AW+1:2];
    assign dm_idx   = bus.dm_addr_i[AW+1:2];
    assign im_fault = (bus.im_addr_i[1:0] != 2'b00) || (bus.im_addr_i[31:AW+2] != '0);
    assign dm_fault = (bus.dm_addr_i[1:0] != 2'b00) || (bus.dm_addr_i[31:AW+2] != '0);

    // Read data is taken from the array before this edge's write lands.
    assign im_rd_d = im_fault ? '0 : im_mem_q[im_idx];
    assign dm_rd_d = (dm_fault || bus.dm_we_i) ? '0 : dm_mem_q[dm_idx];

    always_comb begin
        dm_merge_d = dm_mem_q[dm_idx];
        for (int i = 0; i < 4; i++) begin
            if (bus.dm_be_i[i]) dm_merge_d[8*i +: 8] = bus.dm_wr_data_i[8*i +: 8];
        end
    end

    // Arrays are deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && bus.ld_we_i) im_mem_q[bus.ld_addr_i] <= bus.ld_data_i;
        if (rst_n && bus.dm_req_i && bus.dm_we_i && !dm_fault) dm_mem_q[dm_idx] <= dm_merge_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_v_q <= '0;
            im_e_q <= '0;
            for (int k = 0; k < IM_LAT; k++) im_dat_q[k] <= '0;
        end else begin
            im_v_q[0] <= bus.im_req_i;
            im_e_q[0] <= im_fault;
            if (bus.im_req_i) im_dat_q[0] <= im_rd_d;
            for (int k = 1; k < IM_LAT; k++) begin
                im_v_q[k] <= im_v_q[k-1];
                im_e_q[k] <= im_e_q[k-1];
                if (im_v_q[k-1]) im_dat_q[k] <= im_dat_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_v_q <= '0;
            dm_e_q <= '0;
            for (int k = 0; k < DM_LAT; k++) dm_dat_q[k] <= '0;
        end else begin
            dm_v_q[0] <= bus.dm_req_i;
            dm_e_q[0] <= dm_fault;
            if (bus.dm_req_i) dm_dat_q[0] <= dm_rd_d;
            for (int k = 1; k < DM_LAT; k++) begin
                dm_v_q[k] <= dm_v_q[k-1];
                dm_e_q[k] <= dm_e_q[k-1];
                if (dm_v_q[k-1]) dm_dat_q[k] <= dm_dat_q[k-1];
            end
        end
    end

    // Data stages only advance behind a valid bit, so the output holds its last response.
    assign bus.im_valid_o   = im_v_q[IM_LAT-1];
    assign bus.im_err_o     = im_v_q[IM_LAT-1] & im_e_q[IM_LAT-1];
    assign bus.im_data_o    = im_dat_q[IM_LAT-1];
    assign bus.dm_valid_o   = dm_v_q[DM_LAT-1];
    assign bus.dm_err_o     = dm_v_q[DM_LAT-1] & dm_e_q[DM_LAT-1];
    assign bus.dm_rd_data_o = dm_dat_q[DM_LAT-1];
endmodule

// File: tb/tb_mips_mem_model.sv
// Directed bench for mips_mem_model: three instances with DM latency 1, 3 and 4.
module tb_mips_mem_model;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mips_mem_if #(.AW(10)) ifa ();
    mips_mem_if #(.AW(10)) ifb ();
    mips_mem_if #(.AW(10)) ifc ();

    mips_mem_model #(.AW(10), .IM_LAT(1), .DM_LAT(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    mips_mem_model #(.AW(10), .IM_LAT(2), .DM_LAT(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    mips_mem_model #(.AW(10), .IM_LAT(4), .DM_LAT(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ev;
        logic        ee;
        logic [31:0] ed;
    } dm_vec_t;

    dm_vec_t     vt[19];
    logic [31:0] prog[4];
    logic [31:0] exp_b[3];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        ifa.ld_we_i = 0; ifa.ld_addr_i = '0; ifa.ld_data_i = '0; ifa.im_req_i = 0; ifa.im_addr_i = '0;
        ifa.dm_req_i = 0; ifa.dm_we_i = 0; ifa.dm_be_i = '0; ifa.dm_addr_i = '0; ifa.dm_wr_data_i = '0;
        ifb.ld_we_i = 0; ifb.ld_addr_i = '0; ifb.ld_data_i = '0; ifb.im_req_i = 0; ifb.im_addr_i = '0;
        ifb.dm_req_i = 0; ifb.dm_we_i = 0; ifb.dm_be_i = '0; ifb.dm_addr_i = '0; ifb.dm_wr_data_i = '0;
        ifc.ld_we_i = 0; ifc.ld_addr_i = '0; ifc.ld_data_i = '0; ifc.im_req_i = 0; ifc.im_addr_i = '0;
        ifc.dm_req_i = 0; ifc.dm_we_i = 0; ifc.dm_be_i = '0; ifc.dm_addr_i = '0; ifc.dm_wr_data_i = '0;

        prog  = '{32'h20080005, 32'h20090007, 32'h01095020, 32'hAC0A0010};
        exp_b = '{32'h000000A1, 32'h000000B2, 32'h000000C3};

        //          req we  be       addr           wdata          ev  ee  ed
        vt[0]  = '{1, 1, 4'b1111, 32'h00000040, 32'hDEADBEEF, 1, 0, 32'h0};
        vt[1]  = '{1, 1, 4'b0001, 32'h00000040, 32'h000000AA, 1, 0, 32'h0};
        vt[2]  = '{1, 0, 4'b1111, 32'h00000040, 32'h0,        1, 0, 32'hDEADBEAA};
        vt[3]  = '{1, 1, 4'b0000, 32'h00000040, 32'h12345678, 1, 0, 32'h0};
        vt[4]  = '{1, 0, 4'b0000, 32'h00000040, 32'h0,        1, 0, 32'hDEADBEAA};
        vt[5]  = '{0, 0, 4'b0000, 32'h00000000, 32'h0,        0, 0, 32'hDEADBEAA};
        vt[6]  = '{1, 1, 4'b1111, 32'h00000044, 32'h11223344, 1, 0, 32'h0};
        vt[7]  = '{1, 1, 4'b0110, 32'h00000044, 32'hAABBCCDD, 1, 0, 32'h0};
        vt[8]  = '{1, 0, 4'b0000, 32'h00000044, 32'h0,        1, 0, 32'h11BBCC44};
        vt[9]  = '{1, 0, 4'b0000, 32'h00000042, 32'h0,        1, 1, 32'h0};
        vt[10] = '{1, 1, 4'b1111, 32'h00000000, 32'h0BADF00D, 1, 0, 32'h0};
        vt[11] = '{1, 1, 4'b1111, 32'h00001000, 32'h55555555, 1, 1, 32'h0};
        vt[12] = '{1, 0, 4'b0000, 32'h00000000, 32'h0,        1, 0, 32'h0BADF00D};
        vt[13] = '{1, 1, 4'b1111, 32'h00000043, 32'hFFFFFFFF, 1, 1, 32'h0};
        vt[14] = '{1, 0, 4'b0000, 32'h00000040, 32'h0,        1, 0, 32'hDEADBEAA};
        vt[15] = '{1, 1, 4'b1111, 32'h00000FFC, 32'h87654321, 1, 0, 32'h0};
        vt[16] = '{1, 0, 4'b0000, 32'h00000FFC, 32'h0,        1, 0, 32'h87654321};
        vt[17] = '{0, 0, 4'b0000, 32'h00000000, 32'h0,        0, 0, 32'h87654321};
        vt[18] = '{1, 0, 4'b0000, 32'h80000000, 32'h0,        1, 1, 32'h0};

        // Reset: all outputs low after two cycles of reset
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.a.im_valid", 32'(ifa.im_valid_o), 32'h0);
        chk("rst.a.im_err",   32'(ifa.im_err_o),   32'h0);
        chk("rst.a.im_data",  ifa.im_data_o,       32'h0);
        chk("rst.a.dm_valid", 32'(ifa.dm_valid_o), 32'h0);
        chk("rst.a.dm_err",   32'(ifa.dm_err_o),   32'h0);
        chk("rst.a.dm_data",  ifa.dm_rd_data_o,    32'h0);
        chk("rst.b.dm_valid", 32'(ifb.dm_valid_o), 32'h0);
        chk("rst.c.dm_valid", 32'(ifc.dm_valid_o), 32'h0);
        rst_n = 1'b1;
        cyc();

        // Preload and back-to-back fetch
        for (int i = 0; i < 4; i++) begin
            ifa.ld_we_i = 1; ifa.ld_addr_i = 10'(i); ifa.ld_data_i = prog[i];
            cyc();
        end
        ifa.ld_we_i = 0;
        for (int i = 0; i < 4; i++) begin
            ifa.im_req_i = 1; ifa.im_addr_i = 32'(4 * i);
            cyc();
            chk($sformatf("fetch%0d.valid", i), 32'(ifa.im_valid_o), 32'h1);
            chk($sformatf("fetch%0d.err", i),   32'(ifa.im_err_o),   32'h0);
            chk($sformatf("fetch%0d.data", i),  ifa.im_data_o,       prog[i]);
        end
        ifa.im_req_i = 0;
        cyc();
        chk("fetch.idle.valid", 32'(ifa.im_valid_o), 32'h0);
        chk("fetch.idle.hold",  ifa.im_data_o,       prog[3]);

        // DM table, latency 1
        for (int i = 0; i < 19; i++) begin
            ifa.dm_req_i = vt[i].req; ifa.dm_we_i = vt[i].we; ifa.dm_be_i = vt[i].be;
            ifa.dm_addr_i = vt[i].addr; ifa.dm_wr_data_i = vt[i].wdata;
            cyc();
            chk($sformatf("vt%0d.valid", i), 32'(ifa.dm_valid_o), 32'(vt[i].ev));
            chk($sformatf("vt%0d.err", i),   32'(ifa.dm_err_o),   32'(vt[i].ee));
            chk($sformatf("vt%0d.data", i),  ifa.dm_rd_data_o,    vt[i].ed);
        end
        ifa.dm_req_i = 0;

        // Same-edge load and fetch of word 2, plus a misaligned fetch
        ifa.ld_we_i = 1; ifa.ld_addr_i = 10'd2; ifa.ld_data_i = 32'hFFFF0002;
        ifa.im_req_i = 1; ifa.im_addr_i = 32'h8;
        cyc();
        chk("ldfetch.old", ifa.im_data_o, 32'h01095020);
        ifa.ld_we_i = 0; ifa.im_addr_i = 32'h2;
        cyc();
        chk("imfault.err",  32'(ifa.im_err_o), 32'h1);
        chk("imfault.data", ifa.im_data_o,     32'h0);
        ifa.im_addr_i = 32'h8;
        cyc();
        chk("ldfetch.new", ifa.im_data_o, 32'hFFFF0002);
        ifa.im_req_i = 0;

        // Latency 3 on instance B
        for (int i = 0; i < 3; i++) begin
            ifb.dm_req_i = 1; ifb.dm_we_i = 1; ifb.dm_be_i = 4'hF;
            ifb.dm_addr_i = 32'h80 + 32'(4 * i); ifb.dm_wr_data_i = exp_b[i];
            cyc();
        end
        ifb.dm_req_i = 0; ifb.dm_we_i = 0;
        repeat (4) cyc();
        for (int c = 0; c < 5; c++) begin
            ifb.dm_req_i = (c == 0); ifb.dm_addr_i = 32'h80;
            cyc();
            chk($sformatf("lat3.single.c%0d.valid", c), 32'(ifb.dm_valid_o), 32'(c == 2));
            if (c == 2) chk("lat3.single.data", ifb.dm_rd_data_o, exp_b[0]);
        end
        for (int c = 0; c < 7; c++) begin
            ifb.dm_req_i = (c < 3); ifb.dm_addr_i = 32'h80 + 32'(4 * c);
            cyc();
            chk($sformatf("lat3.b2b.c%0d.valid", c), 32'(ifb.dm_valid_o), 32'(c >= 2 && c <= 4));
            if (c >= 2 && c <= 4) chk($sformatf("lat3.b2b.c%0d.data", c), ifb.dm_rd_data_o, exp_b[c-2]);
        end
        ifb.dm_req_i = 0;

        // Reset mid-flight on instance C (latency 4)
        ifc.dm_req_i = 1; ifc.dm_we_i = 1; ifc.dm_be_i = 4'hF;
        ifc.dm_addr_i = 32'h100; ifc.dm_wr_data_i = 32'h5A5A1234;
        cyc();
        ifc.dm_we_i = 0;
        cyc();
        ifc.dm_req_i = 0;
        repeat (3) cyc();
        chk("lat4.pre.valid", 32'(ifc.dm_valid_o), 32'h1);
        chk("lat4.pre.data",  ifc.dm_rd_data_o,    32'h5A5A1234);
        ifc.dm_req_i = 1;
        cyc();
        ifc.dm_req_i = 0;
        cyc();
        rst_n = 1'b0;
        #1;
        chk("midrst.c.valid",   32'(ifc.dm_valid_o), 32'h0);
        chk("midrst.c.data",    ifc.dm_rd_data_o,    32'h0);
        chk("midrst.a.im_data", ifa.im_data_o,       32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk($sformatf("midrst.post.c%0d.valid", c), 32'(ifc.dm_valid_o), 32'h0);
        end
        ifc.dm_req_i = 1; ifc.dm_addr_i = 32'h100;
        ifa.im_req_i = 1; ifa.im_addr_i = 32'h8;
        cyc();
        chk("midrst.im.retained", ifa.im_data_o, 32'hFFFF0002);
        ifc.dm_req_i = 0; ifa.im_req_i = 0;
        repeat (3) cyc();
        chk("midrst.dm.valid",    32'(ifc.dm_valid_o), 32'h1);
        chk("midrst.dm.retained", ifc.dm_rd_data_o,    32'h5A5A1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
